// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX FIFO -> serializer, deserializer -> RX FIFO,
// programmable baud divisor, status word readable by the core.
module uart_mmio #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  uart_op,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]    FullCount = CW'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] MinDiv    = DIV_W'(4);
  localparam logic [1:0] OpPush   = 2'b01;
  localparam logic [1:0] OpPop    = 2'b10;
  localparam logic [1:0] OpConfig = 2'b11;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Upper write-data bits above the divisor width carry no meaning.
  logic unused_data_in;
  assign unused_data_in = ^data_in[31:DIV_W];

  logic [DIV_W-1:0] div_q;
  logic             tx_ovf_q, rx_ovr_q, ferr_q;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [CW-1:0] tx_cnt_q;
  logic          tx_push, tx_load, tx_full;

  assign tx_full = (tx_cnt_q == FullCount);
  // Fullness uses the registered count, so a same-cycle serializer pop does not make room.
  assign tx_push = (uart_op == OpPush) && !tx_full;

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
      if (tx_load) tx_rptr_q <= tx_rptr_q + AW'(1);
      tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_load);
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= data_in[7:0];
  end

  // ---------------- Serializer ----------------
  state_e           tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_tick_q, tx_tick_d, tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             tx_last;

  assign tx_last = (tx_tick_q == tx_div_q - DIV_W'(1));

  // Serializer next state; a new byte loads from IDLE or straight out of STOP
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      StIdle: tx_load = (tx_cnt_q != '0);
      StStart: begin
        if (tx_last) begin
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = StData;
        end else begin
          tx_tick_d = tx_tick_q + DIV_W'(1);
        end
      end
      StData: begin
        if (tx_last) begin
          tx_tick_d = '0;
          tx_sh_d   = tx_sh_q >> 1;
          if (tx_bit_q == 3'd7) tx_state_d = StStop;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_tick_d = tx_tick_q + DIV_W'(1);
        end
      end
      StStop: begin
        if (tx_last) begin
          tx_state_d = StIdle;
          tx_load    = (tx_cnt_q != '0);
        end else begin
          tx_tick_d = tx_tick_q + DIV_W'(1);
        end
      end
      default: tx_state_d = StIdle;
    endcase
    if (tx_load) begin
      tx_sh_d    = tx_mem[tx_rptr_q];
      tx_div_d   = div_q;
      tx_tick_d  = '0;
      tx_state_d = StStart;
    end
  end

  // Serializer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= StIdle;
      tx_tick_q  <= '0;
      tx_div_q   <= DIV_W'(DEFAULT_DIV);
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  // Serial line level from serializer state
  always_comb begin
    unique case (tx_state_q)
      StStart: uart_tx = 1'b0;
      StData:  uart_tx = tx_sh_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // ---------------- Deserializer ----------------
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  state_e           rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_tick_q, rx_tick_d, rx_div_q, rx_div_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_half, rx_full_bit, rx_store, rx_ferr;

  assign rx_half     = (rx_tick_q == (rx_div_q >> 1) - DIV_W'(1));
  assign rx_full_bit = (rx_tick_q == rx_div_q - DIV_W'(1));

  // Deserializer next state; falling edge needs the line seen high first
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q + DIV_W'(1);
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_store   = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        rx_tick_d = '0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_div_d   = div_q;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (rx_half) begin
          rx_tick_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_full_bit) begin
          rx_tick_d = '0;
          rx_sh_d   = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = StStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      StStop: begin
        if (rx_full_bit) begin
          rx_tick_d  = '0;
          rx_state_d = StIdle;
          rx_store   = rx_s2_q;
          rx_ferr    = !rx_s2_q;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // Synchronizer and deserializer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_tick_q  <= '0;
      rx_div_q   <= DIV_W'(DEFAULT_DIV);
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [CW-1:0] rx_cnt_q;
  logic          rx_push, rx_pop, rx_valid, rx_full;

  assign rx_valid = (rx_cnt_q != '0);
  assign rx_full  = (rx_cnt_q == FullCount);
  assign rx_push  = rx_store && !rx_full;
  assign rx_pop   = (uart_op == OpPop) && rx_valid;

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
      rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_q] <= rx_sh_q;
  end

  // Divisor and sticky flags; a same-cycle set wins over a config clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q    <= DIV_W'(DEFAULT_DIV);
      tx_ovf_q <= 1'b0;
      rx_ovr_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (uart_op == OpConfig) begin
        div_q    <= (data_in[DIV_W-1:0] < MinDiv) ? MinDiv : data_in[DIV_W-1:0];
        tx_ovf_q <= 1'b0;
        rx_ovr_q <= 1'b0;
        ferr_q   <= 1'b0;
      end
      if ((uart_op == OpPush) && tx_full) tx_ovf_q <= 1'b1;
      if (rx_store && rx_full)            rx_ovr_q <= 1'b1;
      if (rx_ferr)                        ferr_q   <= 1'b1;
    end
  end

  // Read data: RX head on pop, status word otherwise
  always_comb begin
    data_out = '0;
    if (uart_op == OpPop) begin
      if (rx_valid) data_out = {23'b0, 1'b1, rx_mem[rx_rptr_q]};
    end else begin
      data_out = {16'h0, 8'(rx_cnt_q), 1'b0, tx_ovf_q, ferr_q, rx_ovr_q,
                  (tx_state_q != StIdle), (tx_cnt_q == '0), tx_full, rx_valid};
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio against a queue-based behavioural model.
module tb_uart_mmio;

  localparam int Depth = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  uart_op = 2'b00;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       m_ovr = 1'b0, m_ferr = 1'b0, m_tovf = 1'b0;
  int         m_div = 434;

  uart_mmio #(
    .FIFO_DEPTH (Depth),
    .DIV_W      (16),
    .DEFAULT_DIV(434)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_op (uart_op),
    .data_in (data_in),
    .data_out(data_out),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic tfull, input logic tempty,
                                             input logic tbusy);
    logic [31:0] s;
    s = '0;
    s[0]    = (rx_q.size() != 0);
    s[1]    = tfull;
    s[2]    = tempty;
    s[3]    = tbusy;
    s[4]    = m_ovr;
    s[5]    = m_ferr;
    s[6]    = m_tovf;
    s[15:8] = 8'(rx_q.size());
    return s;
  endfunction

  task automatic status_check(input string tag, input logic tfull, input logic tempty,
                              input logic tbusy);
    uart_op = 2'b00;
    #1;
    check(tag, data_out, exp_status(tfull, tempty, tbusy));
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] d);
    uart_op = op;
    data_in = d;
    @(negedge clk);
    uart_op = 2'b00;
    data_in = '0;
  endtask

  task automatic config_div(input logic [31:0] v);
    do_op(2'b11, v);
    m_div  = (v[15:0] < 16'd4) ? 4 : int'(v[15:0]);
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_tovf = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    tx_q.push_back(b);
    do_op(2'b01, {24'b0, b});
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    uart_op = 2'b00;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    tx_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_tovf = 1'b0;
    m_div  = 434;
  endtask

  // Compare the serial line with the frames of the next nbytes expected bytes
  task automatic check_tx_stream(input int nbytes, input int offset);
    for (int i = offset; i < nbytes * 10 * m_div; i++) begin
      int         fr;
      int         bi;
      logic [9:0] frame;
      fr    = i / (10 * m_div);
      bi    = (i % (10 * m_div)) / m_div;
      frame = {1'b1, tx_q[fr], 1'b0};
      check("tx_line", {31'b0, uart_tx}, {31'b0, frame[bi]});
      @(negedge clk);
    end
    repeat (nbytes) void'(tx_q.pop_front());
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (m_div) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (m_div) @(negedge clk);
    end
    uart_rx = stop;
    repeat (m_div) @(negedge clk);
    uart_rx = 1'b1;
    repeat (6) @(negedge clk);
    if (stop) begin
      if (rx_q.size() < Depth) rx_q.push_back(b);
      else                     m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] exp;
    exp = (rx_q.size() != 0) ? {23'b0, 1'b1, rx_q[0]} : 32'h0;
    uart_op = 2'b10;
    #1;
    check(tag, data_out, exp);
    @(negedge clk);
    uart_op = 2'b00;
    if (rx_q.size() != 0) void'(rx_q.pop_front());
  endtask

  initial begin
    @(negedge clk);
    apply_reset();
    status_check("reset_status", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("reset_tx_idle", {31'b0, uart_tx}, 32'h1);
      @(negedge clk);
    end

    // Single directed frame at div=8
    config_div(32'd8);
    push(8'hA5);
    check("tx_start_latency", {31'b0, uart_tx}, 32'h1);
    status_check("tx_queued", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    status_check("tx_busy", 1'b0, 1'b1, 1'b1);
    check_tx_stream(1, 0);
    status_check("tx_done", 1'b0, 1'b1, 1'b0);

    // Back-to-back random frames, no idle gap between them
    for (int i = 0; i < 3; i++) push(8'($urandom));
    check_tx_stream(3, 1);
    status_check("tx_b2b_done", 1'b0, 1'b1, 1'b0);

    // Receive path
    send_frame(8'h3C, 1'b1);
    status_check("rx_one", 1'b0, 1'b1, 1'b0);
    pop_check("rx_pop_3c");
    status_check("rx_after_pop", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1);
    status_check("rx_four", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pop_check("rx_pop_rand");
    pop_check("rx_pop_empty");

    // TX overflow with the serializer stalled on a huge divisor
    config_div(32'h0000_FFFF);
    do_op(2'b01, $urandom);
    repeat (2) @(negedge clk);
    for (int i = 0; i < Depth; i++) do_op(2'b01, $urandom);
    status_check("tx_fill", 1'b1, 1'b0, 1'b1);
    do_op(2'b01, $urandom);
    m_tovf = 1'b1;
    status_check("tx_overflow", 1'b1, 1'b0, 1'b1);
    config_div(32'd8);
    status_check("tx_ovf_clear", 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a frame
    apply_reset();
    status_check("reset_midframe", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("reset_midframe_tx", {31'b0, uart_tx}, 32'h1);
      @(negedge clk);
    end

    // RX overrun and framing error
    config_div(32'd8);
    for (int i = 0; i < Depth + 1; i++) send_frame(8'($urandom), 1'b1);
    status_check("rx_overrun", 1'b0, 1'b1, 1'b0);
    send_frame(8'($urandom), 1'b0);
    status_check("frame_err", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < Depth; i++) pop_check("rx_pop_full");
    status_check("rx_drained", 1'b0, 1'b1, 1'b0);
    config_div(32'd8);
    status_check("flags_clear", 1'b0, 1'b1, 1'b0);

    // Short glitch must not start a byte
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    status_check("rx_glitch", 1'b0, 1'b1, 1'b0);

    // Divisor clamp: 1 -> 4, 40-clk frames
    config_div(32'd1);
    push(8'($urandom));
    @(negedge clk);
    check_tx_stream(1, 0);
    status_check("tx_div4_done", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
    status_check("rx_div4", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pop_check("rx_pop_div4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
